game_tick_ctrl: RTL
===================

Name: game_tick_ctrl

Overview:
Game-speed scheduler for the Runner design. Consumes the 1 ms tick from the clock-divider chain and issues one-cycle game-step pulses at a rate set by the current difficulty level. Tracks elapsed play time in 10 ms units and sequences the game through idle, run, pause and game-over. Sits between the tick divider and the game-logic/scroll engine.

Parameters:
BASE_PERIOD, 50, step period in ms at level 0
PERIOD_DEC, 5, ms removed from the period per level
MIN_PERIOD, 10, floor on the step period in ms
LEVEL_STEPS, 100, steps per level increment
MAX_LEVEL, 7, saturating maximum level (3-bit)

Ports:
clk  in  1  system clock (sole clock)
reset_n  in  1  asynchronous active-low reset
tick_1ms  in  1  one-clk pulse every 1 ms, synchronous to clk
start  in  1  one-clk pulse: begin or restart a game
pause  in  1  one-clk pulse: toggle pause
crash  in  1  one-clk pulse: player collision
step  out  1  one-clk game-step pulse
level  out  3  current difficulty level
elapsed_cs  out  16  play time in 10 ms units
running  out  1  high in RUN
game_over  out  1  high in OVER

Behaviour:
- Reset (async, reset_n low): state IDLE; step=0, level=0, elapsed_cs=0, running=0, game_over=0; internal ms_cnt, cs_ms, step_cnt = 0. Outputs clear immediately, not at the next edge.
- All outputs registered.
- FSM states: IDLE, RUN, PAUSE, OVER.
- IDLE: start -> RUN; counters and level cleared on entry. pause and crash are ignored.
- RUN: pause -> PAUSE; crash -> OVER; start is ignored.
- PAUSE: pause -> RUN; crash -> OVER; start is ignored.
- OVER: start -> RUN with all counters, level and elapsed_cs cleared. Otherwise elapsed_cs and level hold.
- Same-cycle priority: crash > pause > start > tick_1ms. A tick coinciding with a state transition is discarded.
- tick_1ms has no effect outside RUN. ms_cnt and cs_ms are retained across PAUSE, so the step phase resumes where it stopped.
- Period is max(BASE_PERIOD - level*PERIOD_DEC, MIN_PERIOD), computed in 8-bit unsigned with the floor applied before any underflow.
- In RUN, on tick_1ms:
  - if ms_cnt == period-1: ms_cnt <= 0 and step <= 1 for exactly one cycle. Latency is one clk after the qualifying tick.
  - otherwise ms_cnt++.
- On each step pulse:
  - if step_cnt == LEVEL_STEPS-1: step_cnt <= 0 and level++, saturating at MAX_LEVEL (step_cnt keeps wrapping after saturation).
  - otherwise step_cnt++.
  - The new period applies from the next step.
- Elapsed time: cs_ms counts ticks 0..9 in RUN. On the wrap 9->0, elapsed_cs++, saturating at 16'hFFFF (no wrap).
- running = (state==RUN); game_over = (state==OVER).
- Parameter legality, checked at elaboration: MIN_PERIOD >= 2 and BASE_PERIOD <= 255.

Optional Feature:
Macro GAME_TICK_BLINK_EN.
- Defined: adds output blink (1 bit), which toggles every 500 ticks_1ms while in PAUSE or OVER. tick_1ms is counted in those states for this purpose only. blink is 0 on reset and is forced to 0 on entering RUN or IDLE.
- Undefined: the port and its counter are absent; everything else is unchanged.

Decomposition:
- Package game_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, OVER=2'd3), default period/level constants, and a period-from-level function.
- Sub-module elapsed_timer: cs_ms divider plus the saturating 16-bit elapsed_cs counter. Inputs are clk, reset_n, enable (tick qualified by RUN) and clear.

Test Plan:
1. Reset, start, then 50 ticks -> one step pulse exactly 1 clk after tick #50, next after tick #100; elapsed_cs=10 after 100 ticks.
2. Run 100 steps (5000 ticks) -> level=1; next step spacing is 45 ticks.
3. After 20 ticks, pause; send 30 ticks; pause again; send 30 ticks -> running low while paused, no step during pause, step after resume tick #30 (total 50 counted), elapsed_cs unchanged while paused.
4. crash and pause in the same cycle during RUN -> OVER, game_over=1, elapsed_cs frozen; subsequent start -> RUN with level=0, elapsed_cs=0.
5. Drive 800 steps -> level saturates at 7, period 15, level stays 7 after 900 steps; with MIN_PERIOD=20, period floors at 20.
6. reset_n low mid-RUN, between clk edges -> all outputs 0 immediately; after release, start behaves as from a fresh IDLE.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared state encoding, default timing constants and the
//               level-to-step-period helper for the Runner game scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int c_base_period = 50;
    localparam int c_period_dec  = 5;
    localparam int c_min_period  = 10;
    localparam int c_level_steps = 100;
    localparam int c_max_level   = 7;

    // The floor is tested before subtracting so the period never underflows.
    function automatic logic [7:0] period_from_level(
        input logic [2:0] lvl,
        input int         base,
        input int         dec,
        input int         min_p
    );
        int dec_total;
        dec_total = int'(lvl) * dec;
        if (dec_total + min_p >= base) begin
            return 8'(min_p);
        end
        return 8'(base - dec_total);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elapsed_timer.sv
`default_nettype none
// ============================================================================
// Module      : elapsed_timer
// Description : Divides qualified 1 ms ticks by ten and counts play time in
//               10 ms units, saturating at 16'hFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
module elapsed_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    output logic [15:0] elapsed_cs
);

    logic [3:0]  r_cs_ms;
    logic [15:0] r_elapsed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_ms   <= 4'd0;
            r_elapsed <= 16'd0;
        end else if (clear) begin
            r_cs_ms   <= 4'd0;
            r_elapsed <= 16'd0;
        end else if (enable) begin
            if (r_cs_ms == 4'd9) begin
                r_cs_ms <= 4'd0;
                if (r_elapsed != 16'hFFFF) begin
                    r_elapsed <= r_elapsed + 16'd1;
                end
            end else begin
                r_cs_ms <= r_cs_ms + 4'd1;
            end
        end
    end

    assign elapsed_cs = r_elapsed;

endmodule
`default_nettype wire

// File: rtl/game_tick_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_ctrl
// Description : Game-speed scheduler: difficulty-scaled step pulses, play-time
//               tracking and IDLE/RUN/PAUSE/OVER sequencing. Optional blink
//               output enabled by macro GAME_TICK_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_ctrl
    import game_pkg::*;
#(
    parameter int BASE_PERIOD = c_base_period,
    parameter int PERIOD_DEC  = c_period_dec,
    parameter int MIN_PERIOD  = c_min_period,
    parameter int LEVEL_STEPS = c_level_steps,
    parameter int MAX_LEVEL   = c_max_level
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_1ms,
    input  logic        start,
    input  logic        pause,
    input  logic        crash,
    output logic        step,
    output logic [2:0]  level,
    output logic [15:0] elapsed_cs,
    output logic        running,
    output logic        game_over
`ifdef GAME_TICK_BLINK_EN
    ,
    output logic        blink
`endif
);

    localparam int c_step_w = (LEVEL_STEPS > 1) ? $clog2(LEVEL_STEPS) : 1;
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(LEVEL_STEPS - 1);
    localparam logic [2:0]          c_level_max = 3'(MAX_LEVEL);

    if (MIN_PERIOD < 2) begin : g_chk_min_period
        $error("game_tick_ctrl: MIN_PERIOD must be at least 2");
    end
    if (BASE_PERIOD > 255) begin : g_chk_base_period
        $error("game_tick_ctrl: BASE_PERIOD must not exceed 255");
    end

    game_state_t         r_state;
    game_state_t         w_next;
    logic                w_clear;
    logic                w_tick_run;
    logic [7:0]          w_period;
    logic [7:0]          r_ms_cnt;
    logic [c_step_w-1:0] r_step_cnt;
    logic [2:0]          r_level;
    logic                r_step;
    logic                r_running;
    logic                r_game_over;

    // Crash outranks pause, pause outranks start; idle ignores both.
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next  = RUN;
                    w_clear = 1'b1;
                end
            end
            RUN: begin
                if (crash)      w_next = OVER;
                else if (pause) w_next = PAUSE;
            end
            PAUSE: begin
                if (crash)      w_next = OVER;
                else if (pause) w_next = RUN;
            end
            OVER: begin
                if (start) begin
                    w_next  = RUN;
                    w_clear = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_tick_run = tick_1ms && (r_state == RUN) && (w_next == r_state);
    assign w_period   = period_from_level(r_level, BASE_PERIOD, PERIOD_DEC, MIN_PERIOD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ms_cnt    <= 8'd0;
            r_step_cnt  <= '0;
            r_level     <= 3'd0;
            r_step      <= 1'b0;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_running   <= (w_next == RUN);
            r_game_over <= (w_next == OVER);
            r_step      <= 1'b0;
            if (w_clear) begin
                r_ms_cnt   <= 8'd0;
                r_step_cnt <= '0;
                r_level    <= 3'd0;
            end else begin
                if (w_tick_run) begin
                    if (r_ms_cnt >= w_period - 8'd1) begin
                        r_ms_cnt <= 8'd0;
                        r_step   <= 1'b1;
                    end else begin
                        r_ms_cnt <= r_ms_cnt + 8'd1;
                    end
                end
                // Level moves the cycle after the pulse, so the next period uses it.
                if (r_step) begin
                    if (r_step_cnt == c_step_last) begin
                        r_step_cnt <= '0;
                        if (r_level != c_level_max) begin
                            r_level <= r_level + 3'd1;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + c_step_w'(1);
                    end
                end
            end
        end
    end

    elapsed_timer u_elapsed_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (w_tick_run),
        .clear      (w_clear),
        .elapsed_cs (elapsed_cs)
    );

`ifdef GAME_TICK_BLINK_EN
    logic [8:0] r_blink_cnt;
    logic       r_blink;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= 9'd0;
            r_blink     <= 1'b0;
        end else if ((w_next == RUN) || (w_next == IDLE)) begin
            r_blink_cnt <= 9'd0;
            r_blink     <= 1'b0;
        end else if (tick_1ms && ((r_state == PAUSE) || (r_state == OVER))) begin
            if (r_blink_cnt == 9'd499) begin
                r_blink_cnt <= 9'd0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 9'd1;
            end
        end
    end

    assign blink = r_blink;
`endif

    assign step      = r_step;
    assign level     = r_level;
    assign running   = r_running;
    assign game_over = r_game_over;

endmodule
`default_nettype wire
